// File: rtl/pool_pkg.sv
// Shared constants and helpers for the streaming pooling layer.
// Mode encodings and accumulator/shift sizing derived from window edge.
package pool_pkg;

  localparam logic POOL_MODE_MAX = 1'b0;
  localparam logic POOL_MODE_AVG = 1'b1;

  function automatic int pool_shift(input int p);
    return 2 * $clog2(p);
  endfunction

  function automatic int pool_acc_width(input int dw, input int p);
    return dw + pool_shift(p);
  endfunction

endpackage

// File: rtl/pool_reduce_unit.sv
// Per-channel combine of two accumulator operands.
// Max mode keeps the signed maximum, average mode adds.
module pool_reduce_unit
  import pool_pkg::*;
#(
  parameter int W = 10
) (
  input  logic                mode,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y
);

  always_comb begin
    y = (a > b) ? a : b;
    if (mode == POOL_MODE_AVG)
      y = a + b;
  end

endmodule

// File: rtl/stream_pool_layer.sv
// Streaming PxP pooling (max/avg) over raster pixels, one row buffer.
// Define POOL_RELU_EN to clamp negative pooled outputs to zero.
module stream_pool_layer
  import pool_pkg::*;
#(
  parameter int CHANNELS   = 32,
  parameter int DATA_WIDTH = 8,
  parameter int IN_WIDTH   = 40,
  parameter int IN_HEIGHT  = 40,
  parameter int POOL_SIZE  = 2
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           en,
  input  logic                           mode,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           frame_done
);

  localparam int OUT_WIDTH  = IN_WIDTH / POOL_SIZE;
  localparam int OUT_HEIGHT = IN_HEIGHT / POOL_SIZE;
  localparam int ACC_WIDTH  = pool_acc_width(DATA_WIDTH, POOL_SIZE);
  localparam int SHIFT      = pool_shift(POOL_SIZE);
  localparam int LP         = $clog2(POOL_SIZE);
  localparam int CW  = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam int RW  = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
  localparam int OIW = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
  localparam int CROP_W = OUT_WIDTH * POOL_SIZE;
  localparam int CROP_H = OUT_HEIGHT * POOL_SIZE;
  localparam logic [CW-1:0] COL_LAST = CW'(IN_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IN_HEIGHT - 1);

  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          mode_q;
  acc_t          hreg [CHANNELS];
  logic [CHANNELS*ACC_WIDTH-1:0] rbuf [OUT_WIDTH];

  acc_t px    [CHANNELS];
  acc_t hcomb [CHANNELS];
  acc_t hval  [CHANNELS];
  acc_t rb_rd [CHANNELS];
  acc_t vcomb [CHANNELS];
  acc_t wval  [CHANNELS];
  logic [DATA_WIDTH-1:0] r_pre [CHANNELS];
  logic [DATA_WIDTH-1:0] r_fin [CHANNELS];
  logic [CHANNELS*DATA_WIDTH-1:0] res;
  logic [CHANNELS*ACC_WIDTH-1:0]  wflat;

  logic           accept;
  logic           first;
  logic           mode_eff;
  logic           in_range;
  logic           h_first;
  logic           h_last;
  logic           v_first;
  logic           v_last;
  logic           last_px;
  logic [OIW-1:0] oidx;

  assign in_ready = rstn && en && !(out_valid && !out_ready);
  assign accept   = in_valid && in_ready;
  assign first    = (col == '0) && (row == '0);
  // first beat of a frame uses the live mode, the rest use the latch
  assign mode_eff = first ? mode : mode_q;
  assign in_range = (32'(col) < 32'(CROP_W)) &&
                    (32'(row) < 32'(CROP_H));
  assign h_first  = col[LP-1:0] == '0;
  assign h_last   = col[LP-1:0] == '1;
  assign v_first  = row[LP-1:0] == '0;
  assign v_last   = row[LP-1:0] == '1;
  assign last_px  = (col == COL_LAST) && (row == ROW_LAST);
  assign oidx     = OIW'(col >> LP);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [DATA_WIDTH-1:0] s;

    assign s     = in_data[c*DATA_WIDTH +: DATA_WIDTH];
    assign px[c] = {{SHIFT{s[DATA_WIDTH-1]}}, s};

    pool_reduce_unit #(.W(ACC_WIDTH)) u_h (
      .mode (mode_eff),
      .a    (hreg[c]),
      .b    (px[c]),
      .y    (hcomb[c])
    );

    assign hval[c]  = h_first ? px[c] : hcomb[c];
    assign rb_rd[c] = rbuf[oidx][c*ACC_WIDTH +: ACC_WIDTH];

    pool_reduce_unit #(.W(ACC_WIDTH)) u_v (
      .mode (mode_eff),
      .a    (rb_rd[c]),
      .b    (hval[c]),
      .y    (vcomb[c])
    );

    assign wval[c] = v_first ? hval[c] : vcomb[c];
    assign wflat[c*ACC_WIDTH +: ACC_WIDTH] = wval[c];

    assign r_pre[c] = (mode_eff == POOL_MODE_AVG)
                    ? DATA_WIDTH'(wval[c] >>> SHIFT)
                    : DATA_WIDTH'(wval[c]);

`ifdef POOL_RELU_EN
    assign r_fin[c] = r_pre[c][DATA_WIDTH-1] ? '0 : r_pre[c];
`else
    assign r_fin[c] = r_pre[c];
`endif

    assign res[c*DATA_WIDTH +: DATA_WIDTH] = r_fin[c];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col        <= '0;
      row        <= '0;
      mode_q     <= POOL_MODE_MAX;
      out_valid  <= 1'b0;
      out_data   <= '0;
      frame_done <= 1'b0;
      for (int i = 0; i < CHANNELS; i++)
        hreg[i] <= '0;
      for (int j = 0; j < OUT_WIDTH; j++)
        rbuf[j] <= '0;
    end else begin
      frame_done <= accept && last_px;
      if (out_ready)
        out_valid <= 1'b0;
      if (accept) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (first)
          mode_q <= mode;
        if (in_range) begin
          for (int i = 0; i < CHANNELS; i++)
            hreg[i] <= hval[i];
          if (h_last)
            rbuf[oidx] <= wflat;
          if (h_last && v_last) begin
            out_valid <= 1'b1;
            out_data  <= res;
          end
        end
      end
    end
  end

endmodule
